uart_rx_tx_bridge: RTL and testbench
====================================

// Module: uart_rx_tx_bridge
// PURPOSE
//  Byte buffer and transmit sequencer between uart_rx and uart_tx in the echo path.
//  Every rx_done pulse pushes rx dout into a circular FIFO.
//  A drain FSM pops one byte at a time, presents it on tx_data and pulses tx_start.
//  It then waits for uart_tx to finish (tx_busy / tx_done) before popping the next byte.
//  Prevents bytes being lost when rx delivers back-to-back while tx is still busy.
// PARAMETERS
//  DATA_W  8  byte width
//  DEPTH   8  FIFO entries; power of 2, >=2
//  ADDR_W  $clog2(DEPTH)  pointer width; derived, never overridden
// PORTS
//  clk       in   1         system clock
//  rst       in   1         asynchronous active-low reset
//  wr_en     in   1         push strobe; connect to uart_rx rx_done (1-cycle pulse)
//  wr_data   in   DATA_W    push data; connect to uart_rx dout
//  tx_busy   in   1         uart_tx o_tx_busy
//  tx_done   in   1         uart_tx o_tx_done (1-cycle pulse)
//  tx_start  out  1         1-cycle start pulse to uart_tx
//  tx_data   out  DATA_W    byte to uart_tx din; held stable from tx_start until tx_done
//  full      out  1         count==DEPTH
//  empty     out  1         count==0
//  count     out  ADDR_W+1  occupancy, 0..DEPTH
//  overflow  out  1         1-cycle pulse: push dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): pointers=0, count=0, state=IDLE; tx_start=0, tx_data=0, empty=1, full=0, overflow=0.
//  Storage: wr_ptr/rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0; count is held separately.
//  Push: when wr_en=1 and (!full or pop this cycle), write mem[wr_ptr] and wr_ptr++.
//    A push while full with no same-cycle pop is dropped, and overflow=1 on the next cycle.
//  Pop: only in IDLE, when !empty and !tx_busy.
//    tx_data<=mem[rd_ptr]; rd_ptr++; go to START.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Push into empty FIFO: the pop is not taken that cycle; empty is sampled before the write.
//  FSM (registered; tx_start is a Moore output, =1 only in START):
//   IDLE      -> START      on pop
//   START     -> WAIT_BUSY  unconditionally; one cycle, tx_start=1
//   WAIT_BUSY -> WAIT_DONE  when tx_busy=1
//             -> IDLE       when tx_done=1 (tx finished within the same cycle)
//   WAIT_DONE -> IDLE       when tx_done=1, or when tx_busy=0 (guard against a missed pulse)
//  Latency: a push at cycle N into an empty FIFO with tx idle gives tx_start=1 at N+2.
//  tx_data changes only on a pop; it is held through WAIT_BUSY and WAIT_DONE.
//  At most one byte is in flight; the next pop is no earlier than the cycle after IDLE re-entry.
//  Reset mid-transfer: the FIFO contents are discarded and tx_start is forced to 0 immediately.
//    The state of uart_tx is not this block's concern.
//  All arithmetic is unsigned. count never exceeds DEPTH and never wraps below 0.
// STRUCTURE
//  uart_pkg (shared):
//    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} bridge_state_t
//    localparam UART_DATA_W = 8
//  Sub-module sync_fifo (mem, pointers, count, full/empty, overflow).
//    Reusable for a later tx-side command queue.
//  The bridge top holds only the drain FSM and the tx_data register.
// TESTING
//  T1 reset: hold rst=0 with wr_en pulses -> count=0, empty=1, tx_start=0, tx_data=0.
//  T2 single byte: push 8'h41 at cycle N, tx idle -> tx_start=1 at N+2 only, tx_data=8'h41.
//     A model tx raises busy, then pulses done -> state returns to IDLE, empty=1.
//  T3 burst: push 8'h30..8'h37 on consecutive cycles while tx_busy=1 -> count reaches 8, full=1.
//     Release tx -> exactly 8 tx_start pulses, data in order 30..37.
//  T4 overflow: at full, push 8'hAA -> overflow pulses once, count stays 8, 8'hAA is never transmitted.
//  T5 simultaneous: at count=8, push in the same cycle as a pop -> accepted.
//     count stays 8, no overflow, and the new byte drains last.
//  T6 reset mid-transfer: rst=0 during WAIT_DONE with 3 bytes queued -> immediately empty=1, tx_start=0.
//     After release, no tx_start without a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART echo-path types: drain FSM state encoding and the default byte width.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } bridge_state_t;

endpackage

// File: rtl/uart_rx_tx_bridge_if.sv
// Bundle between the rx side, the bridge and uart_tx: push strobe/data, tx handshake, FIFO status.
interface uart_rx_tx_bridge_if
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = 8
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output wr_en, wr_data, tx_busy, tx_done,
      input  tx_start, tx_data, full, empty, count, overflow
   );

   modport slave (
      input  wr_en, wr_data, tx_busy, tx_done,
      output tx_start, tx_data, full, empty, count, overflow
   );

endinterface

// File: rtl/uart_rx_tx_bridge_fifo.sv
// Circular byte FIFO with separate occupancy count and a one-cycle overflow flag.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   // A same-cycle pop frees a slot, so a push while full is still accepted then.
   assign push    = wr_en && (!full || rd_en);
   assign pop     = rd_en && !empty;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full && !rd_en;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_tx_bridge.sv
// Echo-path bridge: buffers rx bytes and feeds uart_tx one byte at a time via a drain FSM.
module uart_rx_tx_bridge
   import uart_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = 8
) (
   input  logic clk,
   input  logic rst,
   uart_rx_tx_bridge_if.slave bus
);
   bridge_state_t     state_q;
   bridge_state_t     state_d;
   logic              pop;
   logic              tx_start_c;
   logic [DATA_W-1:0] fifo_rd_data;
   logic [DATA_W-1:0] tx_data_q;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bus.wr_en),
      .wr_data  (bus.wr_data),
      .rd_en    (pop),
      .rd_data  (fifo_rd_data),
      .full     (bus.full),
      .empty    (bus.empty),
      .count    (bus.count),
      .overflow (bus.overflow)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // WAIT_DONE also leaves on busy low so a missed done pulse cannot hang the drain.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (pop) state_d = START;
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy)      state_d = WAIT_DONE;
            else if (bus.tx_done) state_d = IDLE;
         end
         WAIT_DONE: if (bus.tx_done || !bus.tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // empty is the registered count, so a byte written this cycle is not popped until the next.
   always_comb begin
      tx_start_c = (state_q == START);
      pop        = (state_q == IDLE) && !bus.empty && !bus.tx_busy;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data_q <= '0;
      end else if (pop) begin
         tx_data_q <= fifo_rd_data;
      end
   end

   assign bus.tx_start = tx_start_c;
   assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_rx_tx_bridge.sv
// Scenario bench for uart_rx_tx_bridge with a behavioural uart_tx and an expected-byte queue.
module tb_uart_rx_tx_bridge;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_tx_bridge_if #(.DATA_W(8), .DEPTH(8)) bif ();

   uart_rx_tx_bridge #(.DATA_W(8), .DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];

   logic tx_hold    = 1'b0;
   logic model_busy = 1'b0;
   int   model_cnt  = 0;

   assign bif.tx_busy = tx_hold | model_busy;

   // Behavioural uart_tx: busy for three cycles after a start, then a done pulse.
   initial begin
      bif.tx_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            model_cnt   = 0;
            model_busy  = 1'b0;
            bif.tx_done = 1'b0;
         end else begin
            bif.tx_done = 1'b0;
            if (model_cnt > 0) begin
               model_cnt--;
               if (model_cnt == 0) begin
                  model_busy  = 1'b0;
                  bif.tx_done = 1'b1;
               end
            end else if (bif.tx_start) begin
               model_busy = 1'b1;
               model_cnt  = 3;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_burst(input logic [7:0] first, input int n, input bit accept);
      for (int i = 0; i < n; i++) begin
         bif.wr_en   = 1'b1;
         bif.wr_data = first + 8'(i);
         if (accept) exp_q.push_back(first + 8'(i));
         step();
      end
      bif.wr_en = 1'b0;
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (bif.tx_start) seen = 1'b1;
         else step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bif.wr_en   = 1'b1;
         bif.wr_data = 8'hFF;
         step();
      end
      bif.wr_en = 1'b0;
      n_checks++; if (bif.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bif.count); else n_pass++;
      n_checks++; if (bif.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bif.empty); else n_pass++;
      n_checks++; if (bif.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bif.full); else n_pass++;
      n_checks++; if (bif.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bif.tx_start); else n_pass++;
      n_checks++; if (bif.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bif.tx_data); else n_pass++;
      n_checks++; if (bif.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bif.overflow); else n_pass++;
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_byte();
      logic [7:0] exp;
      push_burst(8'h41, 1, 1'b1);
      n_checks++; if (bif.tx_start !== 1'b0) $display("FAIL single_start_n1: got %b want 0", bif.tx_start); else n_pass++;
      step();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (bif.tx_start !== 1'b1) $display("FAIL single_start_n2: got %b want 1", bif.tx_start); else n_pass++;
      n_checks++; if (bif.tx_data !== exp) $display("FAIL single_data: got %h want %h", bif.tx_data, exp); else n_pass++;
      step();
      n_checks++; if (bif.tx_start !== 1'b0) $display("FAIL single_start_n3: got %b want 0", bif.tx_start); else n_pass++;
      repeat (8) step();
      n_checks++; if (bif.empty !== 1'b1) $display("FAIL single_empty: got %b want 1", bif.empty); else n_pass++;
      n_checks++; if (dut.state_q !== IDLE) $display("FAIL single_idle: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
      n_checks++; if (bif.tx_data !== 8'h41) $display("FAIL single_hold: got %h want 41", bif.tx_data); else n_pass++;
   endtask

   task automatic test_burst();
      tx_hold = 1'b1;
      step();
      push_burst(8'h30, 8, 1'b1);
      n_checks++; if (bif.count !== 4'd8) $display("FAIL burst_count: got %0d want 8", bif.count); else n_pass++;
      n_checks++; if (bif.full !== 1'b1) $display("FAIL burst_full: got %b want 1", bif.full); else n_pass++;
      n_checks++; if (bif.tx_start !== 1'b0) $display("FAIL burst_no_start: got %b want 0", bif.tx_start); else n_pass++;
   endtask

   task automatic test_overflow();
      push_burst(8'hAA, 1, 1'b0);
      n_checks++; if (bif.overflow !== 1'b1) $display("FAIL ovf_pulse: got %b want 1", bif.overflow); else n_pass++;
      n_checks++; if (bif.count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", bif.count); else n_pass++;
      step();
      n_checks++; if (bif.overflow !== 1'b0) $display("FAIL ovf_once: got %b want 0", bif.overflow); else n_pass++;
      n_checks++; if (bif.count !== 4'd8) $display("FAIL ovf_count2: got %0d want 8", bif.count); else n_pass++;
   endtask

   task automatic test_simultaneous();
      bit         seen;
      logic [7:0] exp;
      int         extra;
      tx_hold     = 1'b0;
      bif.wr_en   = 1'b1;
      bif.wr_data = 8'h55;
      exp_q.push_back(8'h55);
      step();
      bif.wr_en = 1'b0;
      n_checks++; if (bif.count !== 4'd8) $display("FAIL simul_count: got %0d want 8", bif.count); else n_pass++;
      n_checks++; if (bif.overflow !== 1'b0) $display("FAIL simul_no_ovf: got %b want 0", bif.overflow); else n_pass++;
      for (int k = 0; k < 9; k++) begin
         wait_start(seen);
         n_checks++; if (seen !== 1'b1) $display("FAIL drain_start_%0d: got no tx_start want tx_start", k); else n_pass++;
         if (seen) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (bif.tx_data !== exp) $display("FAIL drain_data_%0d: got %h want %h", k, bif.tx_data, exp); else n_pass++;
            step();
         end
      end
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         if (bif.tx_start) extra++;
         step();
      end
      n_checks++; if (extra !== 0) $display("FAIL drain_extra: got %0d starts want 0", extra); else n_pass++;
      n_checks++; if (bif.empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", bif.empty); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit         seen;
      logic [7:0] exp;
      int         extra;
      push_burst(8'h61, 4, 1'b1);
      n_checks++; if (dut.state_q !== WAIT_DONE) $display("FAIL mid_state: got %0d want %0d", dut.state_q, WAIT_DONE); else n_pass++;
      n_checks++; if (bif.count !== 4'd3) $display("FAIL mid_count: got %0d want 3", bif.count); else n_pass++;
      rst = 1'b0;
      #1;
      exp_q.delete();
      n_checks++; if (bif.empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", bif.empty); else n_pass++;
      n_checks++; if (bif.count !== 4'd0) $display("FAIL mid_count0: got %0d want 0", bif.count); else n_pass++;
      n_checks++; if (bif.tx_start !== 1'b0) $display("FAIL mid_tx_start: got %b want 0", bif.tx_start); else n_pass++;
      n_checks++; if (bif.tx_data !== 8'h00) $display("FAIL mid_tx_data: got %h want 00", bif.tx_data); else n_pass++;
      step();
      step();
      rst = 1'b1;
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         if (bif.tx_start) extra++;
         step();
      end
      n_checks++; if (extra !== 0) $display("FAIL mid_no_start: got %0d starts want 0", extra); else n_pass++;
      push_burst(8'h7E, 1, 1'b1);
      wait_start(seen);
      n_checks++; if (seen !== 1'b1) $display("FAIL mid_restart: got no tx_start want tx_start"); else n_pass++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++; if (bif.tx_data !== exp) $display("FAIL mid_restart_data: got %h want %h", bif.tx_data, exp); else n_pass++;
      repeat (10) step();
   endtask

   initial begin
      bif.wr_en   = 1'b0;
      bif.wr_data = 8'h00;
      #2;
      test_reset();
      test_single_byte();
      test_burst();
      test_overflow();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
